tile_grid_ctrl: RTL

Owns the per-cell tile-type grid of the playfield and drives the tile renderer (TileMap). Each cycle it converts the current VGA pixel coordinate into a cell index and in-cell offsets, then presents the cell's stored type and offsets to the renderer. It also arbitrates grid writes between the level loader and the game-logic hit path. A clear sequencer resets the whole grid to background between levels.

---
 rtl/tile_pkg.sv | 33 +++
 rtl/tile_wr_arb.sv | 48 ++++
 rtl/tile_grid_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/tile_pkg.sv
`default_nettype none
// ============================================================================
// Module  : tile_pkg
// Purpose : Shared tile encodings, grid defaults and controller state values.
// Revision: 1.0 - initial release
// ============================================================================
package tile_pkg;

    localparam int DEF_COLS   = 8;
    localparam int DEF_ROWS   = 6;
    localparam int DEF_TILE_W = 80;
    localparam int DEF_TILE_H = 80;

    typedef enum logic [1:0] {
        BACKGROUND = 2'b00,
        FLOOR      = 2'b01,
        GIFT       = 2'b10,
        RSVD       = 2'b11
    } tile_t;

    typedef enum logic [1:0] {
        CTRL_IDLE  = 2'd0,
        CTRL_CLEAR = 2'd1,
        CTRL_DONE  = 2'd2
    } ctrl_state_t;

    // The reserved code never reaches storage; it collapses to background.
    function automatic logic [1:0] tile_store_value(input logic [1:0] t);
        return (t == RSVD) ? BACKGROUND : t;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tile_wr_arb.sv
`default_nettype none
// ============================================================================
// Module  : tile_wr_arb
// Purpose : Loader/hit write arbiter; TILE_RR_ARB_EN selects round-robin.
// Revision: 1.0 - initial release
// ============================================================================
module tile_wr_arb (
    input  logic clk,
    input  logic resetN,
    input  logic enable,
    input  logic ld_valid,
    input  logic hit_valid,
    output logic ld_grant,
    output logic hit_grant
);

    logic prio_ld;
    logic prio_ld_nxt;

    always_comb begin
        ld_grant  = enable && ld_valid && (!hit_valid || prio_ld);
        hit_grant = enable && hit_valid && !ld_grant;
    end

`ifdef TILE_RR_ARB_EN
    always_comb begin
        prio_ld_nxt = prio_ld;
        if (ld_grant)
            prio_ld_nxt = 1'b0;
        else if (hit_grant)
            prio_ld_nxt = 1'b1;
    end
`else
    // Fixed priority: the pointer is pinned to the loader.
    always_comb begin
        prio_ld_nxt = 1'b1;
    end
`endif

    always_ff @(posedge clk) begin
        if (!resetN)
            prio_ld <= 1'b1;
        else
            prio_ld <= prio_ld_nxt;
    end

endmodule
`default_nettype wire

// File: rtl/tile_grid_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tile_grid_ctrl
// Purpose : Tile-type grid, pixel-to-cell lookup, write arbitration and clear
//           sequencer. Optional macro: TILE_RR_ARB_EN (round-robin writes).
// Revision: 1.0 - initial release
// ============================================================================
module tile_grid_ctrl
    import tile_pkg::*;
#(
    parameter int COLS   = DEF_COLS,
    parameter int ROWS   = DEF_ROWS,
    parameter int TILE_W = DEF_TILE_W,
    parameter int TILE_H = DEF_TILE_H,
    parameter int IDX_W  = $clog2(COLS * ROWS)
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic [10:0]      pixelX,
    input  logic [10:0]      pixelY,
    input  logic             clearReq,
    input  logic             ldValid,
    input  logic [IDX_W-1:0] ldIdx,
    input  logic [1:0]       ldType,
    output logic             ldReady,
    input  logic             hitValid,
    input  logic [IDX_W-1:0] hitIdx,
    input  logic [1:0]       hitType,
    output logic             hitReady,
    output logic [10:0]      offsetX,
    output logic [10:0]      offsetY,
    output logic [1:0]       Tile_type,
    output logic [IDX_W-1:0] tileIdx,
    output logic             busy,
    output logic             clearDone
);

    localparam int CELLS = COLS * ROWS;
    localparam int PF_W  = COLS * TILE_W;
    localparam int PF_H  = ROWS * TILE_H;

    localparam logic [1:0] S_IDLE  = CTRL_IDLE;
    localparam logic [1:0] S_CLEAR = CTRL_CLEAR;
    localparam logic [1:0] S_DONE  = CTRL_DONE;

    logic [1:0]       state;
    logic [IDX_W-1:0] clr_cnt;
    logic [1:0]       grid     [CELLS];
    logic [1:0]       grid_nxt [CELLS];

    logic             ld_grant;
    logic             hit_grant;
    logic [IDX_W-1:0] wr_idx;
    logic [1:0]       wr_type;
    logic             wr_in_range;

    logic [IDX_W-1:0] lk_col;
    logic [IDX_W-1:0] lk_row_base;
    logic [10:0]      lk_x_base;
    logic [10:0]      lk_y_base;
    logic             lk_inside;

    tile_wr_arb u_arb (
        .clk       (clk),
        .resetN    (resetN),
        .enable    (resetN && (state == S_IDLE)),
        .ld_valid  (ldValid),
        .hit_valid (hitValid),
        .ld_grant  (ld_grant),
        .hit_grant (hit_grant)
    );

    assign ldReady   = ld_grant;
    assign hitReady  = hit_grant;
    assign busy      = (state != S_IDLE);
    assign clearDone = (state == S_DONE);

    assign wr_idx      = ld_grant ? ldIdx : hitIdx;
    assign wr_type     = tile_store_value(ld_grant ? ldType : hitType);
    assign wr_in_range = (32'(wr_idx) < CELLS);

    // Cell coordinates by counting crossed tile boundaries, avoiding a divider.
    always_comb begin
        lk_col      = '0;
        lk_row_base = '0;
        lk_x_base   = '0;
        lk_y_base   = '0;
        for (int k = 1; k < COLS; k++) begin
            if (pixelX >= 11'(k * TILE_W)) begin
                lk_col    = lk_col + 1'b1;
                lk_x_base = 11'(k * TILE_W);
            end
        end
        for (int k = 1; k < ROWS; k++) begin
            if (pixelY >= 11'(k * TILE_H)) begin
                lk_row_base = lk_row_base + IDX_W'(COLS);
                lk_y_base   = 11'(k * TILE_H);
            end
        end
        lk_inside = (pixelX < 11'(PF_W)) && (pixelY < 11'(PF_H));
    end

    always_comb begin
        grid_nxt = grid;
        if (state == S_CLEAR)
            grid_nxt[clr_cnt] = BACKGROUND;
        else if ((ld_grant || hit_grant) && wr_in_range)
            grid_nxt[wr_idx] = wr_type;
    end

    always_ff @(posedge clk) begin
        if (!resetN)
            grid <= '{default: BACKGROUND};
        else
            grid <= grid_nxt;
    end

    // Reads the pre-edge grid, so a same-cycle write shows up one cycle later.
    always_ff @(posedge clk) begin
        if (!resetN || !lk_inside) begin
            offsetX   <= '0;
            offsetY   <= '0;
            Tile_type <= BACKGROUND;
            tileIdx   <= '0;
        end else begin
            offsetX   <= pixelX - lk_x_base;
            offsetY   <= pixelY - lk_y_base;
            Tile_type <= grid[lk_row_base + lk_col];
            tileIdx   <= lk_row_base + lk_col;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state   <= S_IDLE;
            clr_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    clr_cnt <= '0;
                    if (clearReq)
                        state <= S_CLEAR;
                end
                S_CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == IDX_W'(CELLS - 1))
                        state <= S_DONE;
                end
                S_DONE: begin
                    clr_cnt <= '0;
                    state   <= S_IDLE;
                end
                default: begin
                    clr_cnt <= '0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
